pc_control_unit: RTL and testbench

Parametrised program-counter unit for the 16-bit core: PC register, PC+2 incrementer, PC-relative branch and register-indirect (BR) targets.
- Adds over the prior PC block: internal Z/N/V flag register with per-flag write enables, stall hold, and a HALT state machine.
- Sits between fetch (consumes pc) and decode/execute (supplies branch controls, flags, register operand).

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/pc_cond_eval.sv | 31 +++
 rtl/pc_control_unit.sv | 95 +++++++++
 tb/tb_pc_control_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core: condition codes, flag indices, PC unit states.
package cpu_pkg;

  localparam logic [2:0] COND_NE     = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_GT     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GE     = 3'b100;
  localparam logic [2:0] COND_LE     = 3'b101;
  localparam logic [2:0] COND_OV     = 3'b110;
  localparam logic [2:0] COND_UNCOND = 3'b111;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    PCS_RUN,
    PCS_HALTED
  } pc_state_t;

endpackage

// File: rtl/pc_cond_eval.sv
// Branch condition evaluation against the registered {Z,N,V} flags.
module pc_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       cond_true
);

  logic z, n, v;

  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      COND_NE:     cond_true = ~z;
      COND_EQ:     cond_true = z;
      COND_GT:     cond_true = ~z & ~n;
      COND_LT:     cond_true = n;
      COND_GE:     cond_true = z | ~n;
      COND_LE:     cond_true = n | z;
      COND_OV:     cond_true = v;
      COND_UNCOND: cond_true = 1'b1;
      default:     cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_control_unit.sv
// Program-counter unit: PC register, PC+2, relative and register-indirect branches,
// flag register with per-bit write enables, stall hold and sticky HALT.
module pc_control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned IMM_W    = 9,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              halt,
  input  logic              branch_en,
  input  logic              br_en,
  input  logic [2:0]        cond,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic [2:0]        flag_we,
  input  logic              z_in,
  input  logic              n_in,
  input  logic              v_in,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus2,
  output logic              taken,
  output logic              halted,
  output logic [2:0]        flags
);

  localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_PC);

  pc_state_t         state;
  logic              cond_true;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] rel_target;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] next_pc;

  pc_cond_eval u_cond (
    .cond      (cond),
    .flags     (flags),
    .cond_true (cond_true)
  );

  // Word offset sign-extended, then scaled to bytes; all sums wrap.
  assign imm_ext    = ADDR_W'($signed(imm));
  assign pc_plus2   = pc + ADDR_W'(2);
  assign rel_target = pc_plus2 + (imm_ext << 1);
  assign br_target  = rs_val & ~ADDR_W'(1);

  assign taken = (state == PCS_RUN) & ~stall & ~halt & (branch_en | br_en) & cond_true;

  always_comb begin
    next_pc = pc_plus2;
    if (taken && br_en) begin
      next_pc = br_target;
    end else if (taken) begin
      next_pc = rel_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_VAL;
      flags  <= 3'b000;
      state  <= PCS_RUN;
      halted <= 1'b0;
    end else begin
      // Flags update in any state, independent of stall.
      if (flag_we[FLAG_Z]) flags[FLAG_Z] <= z_in;
      if (flag_we[FLAG_N]) flags[FLAG_N] <= n_in;
      if (flag_we[FLAG_V]) flags[FLAG_V] <= v_in;

      unique case (state)
        PCS_RUN: begin
          if (!stall) begin
            if (halt) begin
              state  <= PCS_HALTED;
              halted <= 1'b1;
            end else begin
              pc <= next_pc;
            end
          end
        end
        PCS_HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          state <= PCS_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_control_unit.sv
// Scoreboard bench for pc_control_unit: driver pushes expected per-cycle outputs,
// monitor pops and compares at the falling edge.
module tb_pc_control_unit;

  typedef struct {
    logic       stall;
    logic       halt;
    logic       be;
    logic       bre;
    logic [2:0] cond;
    logic [8:0] imm;
    logic [15:0] rs;
    logic [2:0] fwe;
    logic       z;
    logic       n;
    logic       v;
  } vec_t;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] pc;
    logic        taken;
    logic        halted;
    logic [2:0]  flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, halt = 1'b0, branch_en = 1'b0, br_en = 1'b0;
  logic [2:0]  cond = 3'b000;
  logic [8:0]  imm = 9'd0;
  logic [15:0] rs_val = 16'd0;
  logic [2:0]  flag_we = 3'b000;
  logic        z_in = 1'b0, n_in = 1'b0, v_in = 1'b0;
  logic [15:0] pc, pc_plus2;
  logic        taken, halted;
  logic [2:0]  flags;

  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  exp_t sb[$];

  pc_control_unit #(.ADDR_W(16), .IMM_W(9), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .branch_en(branch_en), .br_en(br_en), .cond(cond), .imm(imm),
    .rs_val(rs_val), .flag_we(flag_we), .z_in(z_in), .n_in(n_in), .v_in(v_in),
    .pc(pc), .pc_plus2(pc_plus2), .taken(taken), .halted(halted), .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(logic st, logic hl, logic be, logic bre, logic [2:0] c,
                              logic [8:0] im, logic [15:0] rs, logic [2:0] fwe,
                              logic z, logic n, logic v);
    vec_t r;
    r.stall = st; r.halt = hl; r.be = be; r.bre = bre; r.cond = c; r.imm = im;
    r.rs = rs; r.fwe = fwe; r.z = z; r.n = n; r.v = v;
    return r;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, 0, 3'd0, 9'd0, 16'd0, 3'b000, 0, 0, 0);
  endfunction

  // Drive one cycle's inputs just after the rising edge and queue what must be seen this cycle.
  task automatic step(input string nm, input vec_t v, input logic r, input logic [15:0] epc,
                      input logic et, input logic eh, input logic [2:0] ef);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall = v.stall; halt = v.halt; branch_en = v.be; br_en = v.bre;
    cond = v.cond; imm = v.imm; rs_val = v.rs; flag_we = v.fwe;
    z_in = v.z; n_in = v.n; v_in = v.v;
    e.cyc = cyc; e.name = nm; e.pc = epc; e.taken = et; e.halted = eh; e.flags = ef;
    sb.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        tests++;
        if (e.cyc != cyc || pc !== e.pc || pc_plus2 !== (e.pc + 16'd2) || taken !== e.taken ||
            halted !== e.halted || flags !== e.flags) begin
          failed++;
          $display("FAIL %s: got pc=%h pc+2=%h taken=%b halted=%b flags=%b, want pc=%h pc+2=%h taken=%b halted=%b flags=%b",
                   e.name, pc, pc_plus2, taken, halted, flags,
                   e.pc, e.pc + 16'd2, e.taken, e.halted, e.flags);
        end
      end
    end
  end

  // Condition-code truth masks (bit c = cond c true) for single-flag settings.
  localparam logic [7:0] MASK_000 = 8'h95;
  localparam logic [7:0] MASK_100 = 8'hB2;
  localparam logic [7:0] MASK_010 = 8'hA9;
  localparam logic [7:0] MASK_001 = 8'hD5;

  initial begin
    logic [15:0] epc;
    logic [2:0]  fv [4];
    logic [7:0]  mk_tab [4];
    int          guard;

    fv[0] = 3'b000; mk_tab[0] = MASK_000;
    fv[1] = 3'b100; mk_tab[1] = MASK_100;
    fv[2] = 3'b010; mk_tab[2] = MASK_010;
    fv[3] = 3'b001; mk_tab[3] = MASK_001;

    step("rst_hold", idle(), 1, 16'h0000, 0, 0, 3'b000);
    step("seq0", idle(), 0, 16'h0000, 0, 0, 3'b000);
    step("seq1", idle(), 0, 16'h0002, 0, 0, 3'b000);
    step("seq2", idle(), 0, 16'h0004, 0, 0, 3'b000);
    step("seq3", idle(), 0, 16'h0006, 0, 0, 3'b000);
    step("seq4", idle(), 0, 16'h0008, 0, 0, 3'b000);

    // Reach 0xFFFC by BR while setting Z.
    step("br_setup", mk(0, 0, 0, 1, 3'd7, 9'd0, 16'hFFFC, 3'b100, 1, 0, 0), 0, 16'h000A, 1, 0, 3'b000);
    step("rel_eq_z1", mk(0, 0, 1, 0, 3'd1, 9'h1FE, 16'd0, 3'b000, 0, 0, 0), 0, 16'hFFFC, 1, 0, 3'b100);
    step("br_back_clrz", mk(0, 0, 0, 1, 3'd7, 9'd0, 16'hFFFD, 3'b100, 0, 0, 0), 0, 16'hFFFA, 1, 0, 3'b100);
    step("rel_eq_z0", mk(0, 0, 1, 0, 3'd1, 9'h1FE, 16'd0, 3'b000, 0, 0, 0), 0, 16'hFFFC, 0, 0, 3'b000);

    // Flag write racing a BR: old flags decide, new flags next cycle.
    step("br_race", mk(0, 0, 0, 1, 3'd1, 9'd0, 16'h1235, 3'b100, 1, 0, 0), 0, 16'hFFFE, 0, 0, 3'b000);
    step("br_after", mk(0, 0, 0, 1, 3'd1, 9'd0, 16'h1235, 3'b000, 0, 0, 0), 0, 16'h0000, 1, 0, 3'b100);

    step("stall_br", mk(1, 0, 1, 0, 3'd7, 9'd5, 16'd0, 3'b000, 0, 0, 0), 0, 16'h1234, 0, 0, 3'b100);
    step("unstall_br", mk(0, 0, 1, 0, 3'd7, 9'd5, 16'd0, 3'b000, 0, 0, 0), 0, 16'h1234, 1, 0, 3'b100);
    step("both_br", mk(0, 0, 1, 1, 3'd7, 9'd5, 16'h0040, 3'b000, 0, 0, 0), 0, 16'h1240, 1, 0, 3'b100);

    step("halt_req", mk(0, 1, 1, 0, 3'd7, 9'd5, 16'd0, 3'b000, 0, 0, 0), 0, 16'h0040, 0, 0, 3'b100);
    step("halted_br", mk(0, 0, 1, 1, 3'd7, 9'd5, 16'h0100, 3'b111, 0, 1, 1), 0, 16'h0040, 0, 1, 3'b100);
    step("halted_flags", mk(1, 1, 0, 0, 3'd0, 9'd0, 16'd0, 3'b000, 0, 0, 0), 0, 16'h0040, 0, 1, 3'b011);
    step("halted_sticky", idle(), 0, 16'h0040, 0, 1, 3'b011);

    step("async_rst", idle(), 1, 16'h0000, 0, 0, 3'b000);
    step("rst_held", idle(), 1, 16'h0000, 0, 0, 3'b000);
    step("resume0", idle(), 0, 16'h0000, 0, 0, 3'b000);
    step("resume1", idle(), 0, 16'h0002, 0, 0, 3'b000);

    // Every condition code against single-flag settings; imm=0 keeps the PC stream linear.
    epc = 16'h0004;
    for (int f = 0; f < 4; f++) begin
      step("flag_load", mk(0, 0, 0, 0, 3'd0, 9'd0, 16'd0, 3'b111, fv[f][2], fv[f][1], fv[f][0]),
           0, epc, 0, 0, (f == 0) ? 3'b000 : fv[f - 1]);
      epc = epc + 16'd2;
      for (int c = 0; c < 8; c++) begin
        logic [7:0] m;
        m = mk_tab[f];
        step($sformatf("cond%0d_f%0d", c, f), mk(0, 0, 1, 0, 3'(c), 9'd0, 16'd0, 3'b000, 0, 0, 0),
             0, epc, m[c], 0, fv[f]);
        epc = epc + 16'd2;
      end
    end

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      failed++;
      $display("FAIL drain: %0d expected entries never compared, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
